// File: rtl/branch_predictor_pkg.sv
// Shared sizing and 2-bit counter encodings for the direct-mapped branch predictor.
package branch_predictor_pkg;

   localparam int BP_ENTRIES = 16;
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = 32 - BP_IDX_W - 2;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolution and statistics signals between the pipeline and the predictor.
interface branch_predictor_if;

   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;

   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;

   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] miss_count;

   modport master (
      output if_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, mispredict, redirect_pc,
             branch_count, miss_count
   );

   modport slave (
      input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
             ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, mispredict, redirect_pc,
             branch_count, miss_count
   );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating taken/not-taken counter.
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup, EX-stage
// update/invalidate, misprediction detection and branch/miss statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = BP_ENTRIES
) (
   input  logic               clk,
   input  logic               reset,
   branch_predictor_if.slave  bp
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 32 - IDX_W - 2;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [31:0]        branch_count_q;
   logic [31:0]        miss_count_q;

   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] if_tag;
   logic [TAG_W-1:0] ex_tag;
   logic             if_hit;
   logic             if_pred;
   logic             ex_hit;
   logic             upd_branch;
   logic             alias_kill;
   logic             ex_wrong;
   logic             mispredict;
   logic [1:0]       ex_ctr_next;

   assign if_idx = bp.if_pc[IDX_W+1:2];
   assign if_tag = bp.if_pc[31:IDX_W+2];
   assign ex_idx = bp.ex_pc[IDX_W+1:2];
   assign ex_tag = bp.ex_pc[31:IDX_W+2];

   // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
   assign if_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign if_pred = !reset && if_hit && ctr_q[if_idx][1];

   assign bp.pred_taken  = if_pred;
   assign bp.pred_target = if_pred ? target_q[if_idx] : pc_plus4(bp.if_pc);

   assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign upd_branch = bp.ex_valid && bp.ex_is_branch;
   assign alias_kill = bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken && ex_hit;

   always_comb begin
      ex_wrong = bp.ex_pred_taken;
      if (bp.ex_is_branch) begin
         ex_wrong = (bp.ex_taken != bp.ex_pred_taken) ||
                    (bp.ex_taken && (bp.ex_target != bp.ex_pred_target));
      end
   end

   assign mispredict      = !reset && bp.ex_valid && ex_wrong;
   assign bp.mispredict   = mispredict;
   assign bp.redirect_pc  = (bp.ex_is_branch && bp.ex_taken) ? bp.ex_target
                                                              : pc_plus4(bp.ex_pc);
   assign bp.branch_count = branch_count_q;
   assign bp.miss_count   = miss_count_q;

   sat_counter2 u_sat_counter2 (
      .ctr      (ctr_q[ex_idx]),
      .taken    (bp.ex_taken),
      .ctr_next (ex_ctr_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q        <= '0;
         branch_count_q <= '0;
         miss_count_q   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_q[i] <= CTR_WNT;
         end
      end else begin
         if (upd_branch) begin
            branch_count_q <= branch_count_q + 32'd1;
            if (ex_hit) begin
               ctr_q[ex_idx] <= ex_ctr_next;
               if (bp.ex_taken) target_q[ex_idx] <= bp.ex_target;
            end else if (bp.ex_taken) begin
               valid_q[ex_idx]  <= 1'b1;
               tag_q[ex_idx]    <= ex_tag;
               target_q[ex_idx] <= bp.ex_target;
               ctr_q[ex_idx]    <= CTR_WT;
            end
         end else if (alias_kill) begin
            valid_q[ex_idx] <= 1'b0;
         end
         if (mispredict) miss_count_q <= miss_count_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic
// against an array-based reference model of the predictor table.
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   localparam int N  = 16;
   localparam int IW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_predictor_if bpi ();

   branch_predictor #(.ENTRIES(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bpi.slave)
   );

   typedef struct {
      logic        pt;
      logic [31:0] ptgt;
      logic        mp;
      logic [31:0] rpc;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Reference table: one record per index, counter kept as an integer 0..3.
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];
   logic [31:0] m_bc;
   logic [31:0] m_mc;

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % 32'(N));
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] pc);
      return pc >> (IW + 2);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_pred(logic [31:0] pc);
      return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
      end
      m_bc = '0;
      m_mc = '0;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit rst, input logic [31:0] ipc,
                        input bit ev, input logic [31:0] epc, input bit br,
                        input bit tk, input logic [31:0] etgt,
                        input bit ept, input logic [31:0] eptgt);
      exp_t e;
      bit   lk, wrong, hit;
      int   j;
      @(posedge clk);
      #1;
      reset                 = rst;
      bpi.if_pc             = ipc;
      bpi.ex_valid          = ev;
      bpi.ex_pc             = epc;
      bpi.ex_is_branch      = br;
      bpi.ex_taken          = tk;
      bpi.ex_target         = etgt;
      bpi.ex_pred_taken     = ept;
      bpi.ex_pred_target    = eptgt;

      lk     = !rst && m_pred(ipc);
      e.pt   = lk;
      e.ptgt = lk ? m_tgt[idx_of(ipc)] : ipc + 32'd4;
      wrong  = br ? ((tk != ept) || (tk && etgt != eptgt)) : ept;
      e.mp   = !rst && ev && wrong;
      e.rpc  = (br && tk) ? etgt : epc + 32'd4;
      e.bc   = m_bc;
      e.mc   = m_mc;
      sb.push_back(e);

      // Table effect of this cycle, taking place at the next rising edge.
      if (rst) begin
         m_reset();
      end else begin
         j   = idx_of(epc);
         hit = m_hit(epc);
         if (e.mp) m_mc = m_mc + 32'd1;
         if (ev && br) begin
            m_bc = m_bc + 32'd1;
            if (hit) begin
               m_ctr[j] = tk ? ((m_ctr[j] == 3) ? 3 : m_ctr[j] + 1)
                             : ((m_ctr[j] == 0) ? 0 : m_ctr[j] - 1);
               if (tk) m_tgt[j] = etgt;
            end else if (tk) begin
               m_valid[j] = 1'b1;
               m_tag[j]   = tag_of(epc);
               m_tgt[j]   = etgt;
               m_ctr[j]   = 2;
            end
         end else if (ev && ept && hit) begin
            m_valid[j] = 1'b0;
         end
      end
   endtask

   task automatic idle(input logic [31:0] ipc);
      cycle(1'b0, ipc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("pred_taken",   32'(bpi.pred_taken), 32'(e.pt));
         chk("pred_target",  bpi.pred_target,     e.ptgt);
         chk("mispredict",   32'(bpi.mispredict), 32'(e.mp));
         if (e.mp) chk("redirect_pc", bpi.redirect_pc, e.rpc);
         chk("branch_count", bpi.branch_count,    e.bc);
         chk("miss_count",   bpi.miss_count,      e.mc);
      end
   end

   localparam logic [31:0] PC_A = 32'h0040_0010;
   localparam logic [31:0] PC_B = 32'h0040_0050;
   localparam logic [31:0] PC_C = 32'h0040_0020;
   localparam logic [31:0] PC_D = 32'h0040_0030;
   localparam logic [31:0] T_A  = 32'h0040_0100;
   localparam logic [31:0] T_C  = 32'h0040_0200;

   logic [31:0] tag_pool [3];
   logic [31:0] tgt_pool [4];

   function automatic logic [31:0] rand_pc();
      return (tag_pool[$urandom_range(0, 2)] << (IW + 2)) |
             (32'($urandom_range(0, N - 1)) << 2);
   endfunction

   initial begin
      logic [31:0] ipc, epc, etgt, eptgt;
      bit          br, tk, ept, rst, ev;
      int          wait_cnt;

      tag_pool[0] = 32'h0001_0000;
      tag_pool[1] = 32'h0001_0001;
      tag_pool[2] = 32'h0000_02AB;
      tgt_pool[0] = 32'h0040_0100;
      tgt_pool[1] = 32'h0040_0200;
      tgt_pool[2] = 32'h0000_1000;
      tgt_pool[3] = 32'h0080_0040;

      reset              = 1'b1;
      bpi.if_pc          = PC_A;
      bpi.ex_valid       = 1'b0;
      bpi.ex_pc          = '0;
      bpi.ex_is_branch   = 1'b0;
      bpi.ex_taken       = 1'b0;
      bpi.ex_target      = '0;
      bpi.ex_pred_taken  = 1'b0;
      bpi.ex_pred_target = '0;
      m_reset();
      repeat (2) @(posedge clk);

      // Reset view of a lookup
      cycle(1'b1, PC_A, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      // First taken branch allocates; same-cycle lookup still misses
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b1, T_A, 1'b0, PC_A + 32'd4);
      idle(PC_A);
      // Counter walk: T, T, N, N, N
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b1, T_A, 1'b1, T_A);
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b1, T_A, 1'b1, T_A);
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b0, T_A, 1'b1, T_A);
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b0, T_A, 1'b1, T_A);
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b0, T_A, 1'b0, PC_A + 32'd4);
      idle(PC_A);
      // Re-train to taken, then alias checks
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b1, T_A, 1'b0, PC_A + 32'd4);
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b1, 1'b1, T_A, 1'b0, PC_A + 32'd4);
      idle(PC_A);
      cycle(1'b0, PC_A, 1'b1, PC_B, 1'b0, 1'b0, 32'h0, 1'b1, T_A);
      idle(PC_A);
      cycle(1'b0, PC_A, 1'b1, PC_A, 1'b0, 1'b0, 32'h0, 1'b1, T_A);
      idle(PC_A);
      // Update and lookup of the same index in one cycle
      cycle(1'b0, PC_C, 1'b1, PC_C, 1'b1, 1'b1, T_C, 1'b0, PC_C + 32'd4);
      idle(PC_C);
      // Invalid EX slot ignores everything else
      cycle(1'b0, PC_C, 1'b0, PC_C, 1'b1, 1'b0, T_A, 1'b1, T_C);
      // Reset with a simultaneous taken update
      cycle(1'b1, PC_D, 1'b1, PC_D, 1'b1, 1'b1, T_C, 1'b0, PC_D + 32'd4);
      idle(PC_D);
      idle(PC_C);

      for (int k = 0; k < 600; k++) begin
         rst  = ($urandom_range(0, 99) == 0);
         ev   = ($urandom_range(0, 9) != 0);
         epc  = rand_pc();
         ipc  = ($urandom_range(0, 3) == 0) ? epc : rand_pc();
         br   = ($urandom_range(0, 4) != 0);
         tk   = $urandom_range(0, 1) == 1;
         etgt = tgt_pool[$urandom_range(0, 3)];
         if ($urandom_range(0, 9) < 7) begin
            ept   = m_pred(epc);
            eptgt = ept ? m_tgt[idx_of(epc)] : epc + 32'd4;
         end else begin
            ept   = $urandom_range(0, 1) == 1;
            eptgt = tgt_pool[$urandom_range(0, 3)];
         end
         cycle(rst, ipc, ev, epc, br, tk, etgt, ept, eptgt);
      end

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      @(negedge clk);
      if (sb.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
